// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, read-allocate data cache that
// sits between the MEM stage and the SRAM controller.
//
// Read hits are answered combinationally. Read misses and every store are
// forwarded to the SRAM controller using its own request/busy handshake, and
// the pipeline is frozen until the transfer completes.
//
// Optional feature macro: DCACHE_STATS_EN adds hit_count / miss_count outputs.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   mem_rd_en, mem_wr_en    MEM-stage load / store request (store wins)
//   address, write_data     byte address (bits [1:0] ignored), store data
//   read_data               load data (0 when nothing valid to return)
//   freeze                  pipeline stall
//   sram_rd_en, sram_wr_en  requests to the SRAM controller
//   sram_address, sram_wdata  pass-through of address / write_data
//   sram_rdata, sram_busy   SRAM controller response
//   hit_count, miss_count   (DCACHE_STATS_EN only) 32-bit wrapping counters
module dcache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        freeze,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_busy
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t state, state_nx;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [31:0]         data_mem [LINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   addr_tag;
  logic                  hit;
  logic                  done;
  logic                  rd_hit_idle;
  logic                  fill;
  logic                  wr_upd;

  // Byte offset and address bits above the tag do not take part in lookup.
  logic unused_addr;
  assign unused_addr = ^address;

  assign idx         = address[2 +: INDEX_BITS];
  assign addr_tag    = address[2+INDEX_BITS +: TAG_BITS];
  assign hit         = valid[idx] && (tag_mem[idx] == addr_tag);
  // A transfer finishes on the first request cycle with busy low.
  assign done        = (state != IDLE) && !sram_busy;
  assign rd_hit_idle = (state == IDLE) && mem_rd_en && !mem_wr_en && hit;
  assign fill        = (state == RD_MISS) && done;
  // Write-through with no write-allocate: only an already-present line changes.
  assign wr_upd      = (state == WR_THRU) && done && hit;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (mem_wr_en)            state_nx = WR_THRU;
        else if (mem_rd_en && !hit) state_nx = RD_MISS;
      end
      RD_MISS, WR_THRU: begin
        if (!sram_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign sram_rd_en   = (state == RD_MISS);
  assign sram_wr_en   = (state == WR_THRU);
  assign sram_address = address;
  assign sram_wdata   = write_data;

  assign freeze = (mem_rd_en || mem_wr_en) && !rd_hit_idle && !done;

  always_comb begin
    read_data = '0;
    if (rd_hit_idle) read_data = data_mem[idx];
    else if (fill)   read_data = sram_rdata;  // bypass so the load completes now
  end

  always_ff @(posedge clk) begin
    if (!rst_n)    valid      <= '0;
    else if (fill) valid[idx] <= 1'b1;
  end

  // Tag/data arrays carry no reset; valid bits alone gate them.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (fill) begin
        tag_mem[idx]  <= addr_tag;
        data_mem[idx] <= sram_rdata;
      end else if (wr_upd) begin
        data_mem[idx] <= write_data;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit_idle) hit_count <= hit_count + 32'd1;
      if (state == IDLE && state_nx == RD_MISS) miss_count <= miss_count + 32'd1;
    end
  end
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_rd_en, mem_wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        freeze, sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_wdata, sram_rdata;
  logic        sram_busy;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int n_chk = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  // SRAM controller model: busy for lat_cfg request cycles, then done.
  int lat_cfg = 0;
  int cnt = 0;

  always #5 clk = ~clk;

  assign sram_busy = (sram_rd_en || sram_wr_en) && (cnt < lat_cfg);

  always @(posedge clk) begin
    if ((sram_rd_en || sram_wr_en) && cnt < lat_cfg) cnt <= cnt + 1;
    else cnt <= 0;
  end

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .freeze(freeze),
    .sram_rd_en(sram_rd_en), .sram_wr_en(sram_wr_en),
    .sram_address(sram_address), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .sram_busy(sram_busy)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  task automatic check(input string tg, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tg, act, exp);
    end
  endtask

  task automatic check_stats(input string tg);
`ifdef DCACHE_STATS_EN
    check({tg, "_hits"}, hit_count, 32'(exp_hits));
    check({tg, "_miss"}, miss_count, 32'(exp_miss));
`endif
  endtask

  // Load: counts cycles with sram_rd_en high until freeze drops.
  task automatic do_read(input string tg, input logic [31:0] a, input int lat,
                         input logic [31:0] srd, input bit is_miss, input logic [31:0] exp_data);
    int rd_cyc = 0;
    int loops = 0;
    @(negedge clk);
    lat_cfg = lat; sram_rdata = srd;
    mem_rd_en = 1'b1; address = a;
    #1;
    while (freeze && loops < 50) begin
      if (sram_rd_en) rd_cyc++;
      @(negedge clk); #1;
      loops++;
    end
    if (loops >= 50) check({tg, "_timeout"}, 32'd0, 32'd1);
    if (sram_rd_en) rd_cyc++;
    check({tg, "_data"}, read_data, exp_data);
    check({tg, "_rdcyc"}, 32'(rd_cyc), is_miss ? 32'(lat + 1) : 32'd0);
    if (is_miss) exp_miss++; else exp_hits++;
    @(posedge clk); #1;
    mem_rd_en = 1'b0;
  endtask

  // Store (optionally with a simultaneous load request, which must lose).
  task automatic do_write(input string tg, input logic [31:0] a, input logic [31:0] d,
                          input int lat, input bit with_rd);
    int wr_cyc = 0;
    int rd_cyc = 0;
    int loops = 0;
    @(negedge clk);
    lat_cfg = lat;
    mem_wr_en = 1'b1; mem_rd_en = with_rd; address = a; write_data = d;
    #1;
    while (freeze && loops < 50) begin
      if (sram_wr_en) wr_cyc++;
      if (sram_rd_en) rd_cyc++;
      @(negedge clk); #1;
      loops++;
    end
    if (loops >= 50) check({tg, "_timeout"}, 32'd0, 32'd1);
    if (sram_wr_en) wr_cyc++;
    check({tg, "_wdata"}, sram_wdata, d);
    check({tg, "_waddr"}, sram_address, a);
    check({tg, "_rdata0"}, read_data, 32'd0);
    check({tg, "_wrcyc"}, 32'(wr_cyc), 32'(lat + 1));
    check({tg, "_rdcyc"}, 32'(rd_cyc), 32'd0);
    @(posedge clk); #1;
    mem_wr_en = 1'b0; mem_rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    address = '0; write_data = '0; sram_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_freeze", {31'd0, freeze}, 32'd0);
    check("rst_rden", {31'd0, sram_rd_en}, 32'd0);
    check("rst_wren", {31'd0, sram_wr_en}, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check_stats("rst");
    @(negedge clk); rst_n = 1'b1;

    do_read("miss40", 32'h40, 5, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF);
    do_read("hit40", 32'h40, 5, 32'h0, 1'b0, 32'hDEADBEEF);
    do_write("wr40", 32'h40, 32'h12345678, 3, 1'b0);
    do_read("hit40b", 32'h40, 5, 32'h0, 1'b0, 32'h12345678);
    do_write("wr80", 32'h80, 32'hCAFEF00D, 2, 1'b0);
    do_read("miss80", 32'h80, 2, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D);
    do_write("wrboth", 32'h40, 32'h00000055, 0, 1'b1);
    do_read("hit40c", 32'h40, 1, 32'h0, 1'b0, 32'h00000055);
    do_read("miss140", 32'h140, 1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5);
    do_read("miss40b", 32'h40, 1, 32'h11112222, 1'b1, 32'h11112222);
    do_read("miss140b", 32'h140, 0, 32'h0BADF00D, 1'b1, 32'h0BADF00D);
    check_stats("pre_rst");

    // Reset in the middle of a read miss to 0x200.
    @(negedge clk);
    lat_cfg = 10; sram_rdata = 32'hFFFF0000;
    mem_rd_en = 1'b1; address = 32'h200;
    repeat (4) @(negedge clk);
    #1;
    check("mid_rden", {31'd0, sram_rd_en}, 32'd1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    mem_rd_en = 1'b0;
    check("rst_mid_rden", {31'd0, sram_rd_en}, 32'd0);
    exp_hits = 0; exp_miss = 0;
    check_stats("rst_mid");
    @(negedge clk); rst_n = 1'b1;
    do_read("post_rst140", 32'h140, 1, 32'h77777777, 1'b1, 32'h77777777);
    do_read("post_rst200", 32'h200, 2, 32'h20202020, 1'b1, 32'h20202020);
    do_read("hit140", 32'h140, 1, 32'h0, 1'b0, 32'h77777777);
    check_stats("end");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
